// File: rtl/relm_adc_scan.sv
// relm_adc_scan: autonomous round-robin scan controller for an 8-channel
// ADC128S022-style serial ADC, keeping the latest sample of each channel.
module relm_adc_scan #(
  parameter int WD     = 32,
  parameter int CLKDIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] cfg_d,
  output logic        cfg_retry,
  input  logic [WD:0] rd_d,
  output logic [WD:0] rd_q,
  output logic        adc_cs_n_out,
  output logic        adc_sclk_out,
  output logic        adc_saddr_out,
  input  logic        adc_sdat_in
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD} state_t;
  localparam int HCW = $clog2(CLKDIV);

  state_t           r_state, w_next;
  logic [HCW-1:0]   r_hc;
  logic [3:0]       r_n, w_n_inc;
  logic [7:0]       r_mask, r_pend, w_mask_eff;
  logic             r_cfg_retry;
  logic [2:0]       r_cur_ch, r_prev_ch;
  logic             r_prev_valid;
  logic [11:0]      r_shift;
  logic             r_sdat_m, r_sdat_s;
  logic             r_saddr, w_saddr_nx;
  logic [7:0][11:0] r_smp;
  logic [7:0]       r_fresh;
  logic [WD:0]      r_rd_q, w_rd_word;
  logic             w_last, w_hold_first, w_hold_exit;
  logic             w_unused;

  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) c = 3'(i);
    return c;
  endfunction

  // Next enabled channel strictly after cur, wrapping; cur itself if it is the only one.
  function automatic logic [2:0] f_after(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] c, t;
    c = cur;
    for (int i = 8; i >= 1; i--) begin
      t = cur + 3'(i);
      if (m[t]) c = t;
    end
    return c;
  endfunction

  assign w_unused     = ^{cfg_d[WD-1:8], rd_d[WD-1:3]};
  assign w_last       = (r_hc == HCW'(CLKDIV - 1));
  assign w_hold_first = (r_state == S_HOLD) && (r_hc == '0);
  assign w_hold_exit  = (r_state == S_HOLD) && w_last;
  assign w_mask_eff   = r_cfg_retry ? r_pend : r_mask;
  assign w_n_inc      = r_n + 4'd1;

  always_comb begin
    w_saddr_nx = 1'b0;
    case (w_n_inc)
      4'd2:    w_saddr_nx = r_cur_ch[2];
      4'd3:    w_saddr_nx = r_cur_ch[1];
      4'd4:    w_saddr_nx = r_cur_ch[0];
      default: w_saddr_nx = 1'b0;
    endcase
  end

  always_comb begin
    w_rd_word        = '0;
    w_rd_word[15:0]  = {r_fresh[rd_d[2:0]], rd_d[2:0], r_smp[rd_d[2:0]]};
  end

  always_comb begin
    w_next       = r_state;
    adc_cs_n_out = 1'b1;
    adc_sclk_out = 1'b1;
    case (r_state)
      S_IDLE:  if (r_mask != 8'd0) w_next = S_SETUP;
      S_SETUP: begin
        adc_cs_n_out = 1'b0;
        if (w_last) w_next = S_LOW;
      end
      S_LOW: begin
        adc_cs_n_out = 1'b0;
        adc_sclk_out = 1'b0;
        if (w_last) w_next = S_HIGH;
      end
      S_HIGH: begin
        adc_cs_n_out = 1'b0;
        if (w_last) w_next = (r_n == 4'd15) ? S_HOLD : S_LOW;
      end
      S_HOLD:  if (w_last) w_next = (w_mask_eff != 8'd0) ? S_SETUP : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc         <= '0;
      r_n          <= '0;
      r_mask       <= '0;
      r_pend       <= '0;
      r_cfg_retry  <= 1'b0;
      r_cur_ch     <= '0;
      r_prev_ch    <= '0;
      r_prev_valid <= 1'b0;
      r_shift      <= '0;
      r_sdat_m     <= 1'b0;
      r_sdat_s     <= 1'b0;
      r_saddr      <= 1'b0;
      r_smp        <= '0;
      r_fresh      <= '0;
      r_rd_q       <= '0;
    end else begin
      r_sdat_m <= adc_sdat_in;
      r_sdat_s <= r_sdat_m;
      r_hc     <= (r_state == S_IDLE || w_last) ? '0 : r_hc + HCW'(1);

      if (r_state == S_IDLE && r_mask != 8'd0) r_cur_ch <= f_lowest(r_mask);
      if (r_state == S_SETUP && w_last) begin
        r_n     <= 4'd0;
        r_saddr <= 1'b0;
      end
      if (r_state == S_HIGH && w_last) begin
        if (r_n >= 4'd4) r_shift <= {r_shift[10:0], r_sdat_s};
        if (r_n != 4'd15) begin
          r_n     <= w_n_inc;
          r_saddr <= w_saddr_nx;
        end
      end

      // Result of this frame belongs to the channel addressed one frame earlier.
      if (w_hold_first) begin
        r_prev_ch    <= r_cur_ch;
        r_prev_valid <= 1'b1;
      end
      if (w_hold_exit) begin
        if (w_mask_eff != 8'd0) r_cur_ch <= f_after(w_mask_eff, r_cur_ch);
        else                    r_prev_valid <= 1'b0;
      end

      if (cfg_d[WD] && !r_cfg_retry) begin
        r_pend      <= cfg_d[7:0];
        r_cfg_retry <= 1'b1;
      end else if (r_cfg_retry && (r_state == S_IDLE || w_hold_exit)) begin
        r_mask      <= r_pend;
        r_cfg_retry <= 1'b0;
      end

      if (rd_d[WD]) begin
        r_rd_q             <= w_rd_word;
        r_fresh[rd_d[2:0]] <= 1'b0;
      end
      // A same-cycle write wins over the read's fresh clear.
      if (w_hold_first && r_prev_valid) begin
        r_smp[r_prev_ch]   <= r_shift;
        r_fresh[r_prev_ch] <= 1'b1;
      end
    end
  end

  assign cfg_retry     = r_cfg_retry;
  assign rd_q          = r_rd_q;
  assign adc_saddr_out = r_saddr;
endmodule
